leg_bus_arbiter: RTL
====================

// Module: leg_bus_arbiter
// PURPOSE
//   Round-robin arbiter that shares the tri-state data bus between up to 16 requesters.
//   It drives the select bits and Disable of the 4-bit select decoder.
//   Inserts one dead (turnaround) cycle between owners so two drivers never contend.
//   Bounds bus tenure with a hold limit unless the owner asserts lock.
// PARAMETERS
//   NUM_REQ   16  number of requesters, legal 2..16; req bits >= NUM_REQ ignored
//   MAX_HOLD  8   max consecutive GRANT cycles while others wait; 0 = no preemption
// PORTS
//   clk          in   1   single clock, rising edge
//   rst          in   1   asynchronous, active-high reset
//   req          in   16  request vector, bit i = requester i (level, held until done)
//   lock         in   1   owner forbids hold-limit preemption while 1
//   grant_valid  out  1   a requester owns the bus this cycle
//   grant_idx    out  4   owner index; to decoder bit1..bit4 (bit1 = LSB)
//   grant_oh     out  16  one-hot of grant_idx when grant_valid, else 0
//   bus_disable  out  1   to decoder Disable; == ~grant_valid
//   hold_cnt     out  4   cycles current owner has held bus (saturating, debug)
// BEHAVIOUR
//   Clock and reset: one clock domain (clk). rst is asynchronous and active-high.
//   Reset values: state=IDLE, grant_valid=0, grant_idx=0, grant_oh=0, bus_disable=1,
//     hold_cnt=0, rr_ptr=0. Reset mid-grant drops the bus immediately, no turnaround.
//   All outputs are registered. There is no combinational path from req or lock to any output.
//   Arbitration function pick(): first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ...
//     wrapping modulo NUM_REQ.
//   FSM states: IDLE, GRANT, TURN.
//   IDLE:
//     - Any valid req: load grant_idx=pick(), grant_valid=1, hold_cnt=0, go to GRANT.
//       Latency: req rising in cycle N gives grant_valid=1 in cycle N+1.
//     - No req: stay in IDLE.
//   GRANT:
//     - Each cycle the owner is kept, hold_cnt increments, saturating at 15.
//     - Release when req[grant_idx]=0.
//     - Also release (preempt) when MAX_HOLD!=0, hold_cnt>=MAX_HOLD-1, lock=0, and any
//       other req bit is set.
//     - On release: grant_valid=0 next cycle, rr_ptr=(grant_idx+1) mod NUM_REQ,
//       go to TURN. grant_idx keeps its old value and is don't-care while invalid.
//     - If drop and preempt are both true in the same cycle, treat it as a drop.
//       The result is identical.
//   TURN (exactly 1 cycle, grant_valid=0, bus_disable=1):
//     - Any valid req: register new owner=pick() with the updated rr_ptr, go to GRANT.
//       Bus-idle gap between owners is exactly 1 cycle.
//     - No req: go to IDLE.
//     - A preempted owner that is still requesting is re-granted only after every
//       requester between it and rr_ptr has been served.
//   Sole requester with MAX_HOLD reached: no preemption, because no other req is set.
//     The owner keeps the bus.
//   Requester that drops req in the same cycle it is granted:
//     - It still owns the bus for that one cycle.
//     - Release is then seen, giving a 1-cycle grant followed by TURN.
//   Wrap-around: owner NUM_REQ-1 releases, so rr_ptr becomes 0.
//   Invariants:
//     - grant_oh has at most one bit set.
//     - grant_valid never rises in the cycle directly after it fell.
// TESTING
//   1. rst, req=0x0000 -> bus_disable=1, grant_oh=0, state IDLE; assert rst mid-grant -> outputs reset same cycle (async)
//   2. req=0x0010 at cycle N -> cycle N+1 grant_valid=1, grant_idx=4, grant_oh=0x0010; drop req -> 1 TURN cycle -> IDLE
//   3. req=0x8001 constant, MAX_HOLD=8, lock=0 -> owners 0,15,0,15...; each tenure 8 cycles, 1-cycle gap, never overlapping
//   4. req=0x0006, lock=1 held by owner 1 for 20 cycles -> owner 1 keeps bus all 20, hold_cnt saturates at 15; lock=0 -> owner 2 after TURN
//   5. rr_ptr=15: owner 15 releases with req=0x8003 -> next owner 0 (wrap), then 1, then 15
//   6. NUM_REQ=4, req=0xFFF0 -> no grant ever; req=0x0008 -> grant_idx=3

Source files
------------

// File: rtl/leg_bus_arbiter.sv
// Round-robin arbiter for a shared tri-state bus with up to 16 requesters.
// Inserts a one-cycle turnaround between owners and bounds tenure unless locked.
module leg_bus_arbiter #(
  parameter int unsigned NUM_REQ  = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] req_i,
  input  logic        lock_i,
  output logic        grant_valid_o,
  output logic [3:0]  grant_idx_o,
  output logic [15:0] grant_oh_o,
  output logic        bus_disable_o,
  output logic [3:0]  hold_cnt_o
);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  localparam logic [15:0] ReqMask = 16'((32'd1 << NUM_REQ) - 32'd1);
  localparam int          HoldLim = int'(MAX_HOLD) - 1;

  state_e      state_q;
  logic [3:0]  rr_ptr_q;
  logic        grant_valid_q;
  logic [3:0]  grant_idx_q;
  logic [15:0] grant_oh_q;
  logic        bus_disable_q;
  logic [3:0]  hold_cnt_q;

  logic [15:0] req_v;
  logic        pick_found;
  logic [3:0]  pick_idx;
  logic [4:0]  cand;
  logic [4:0]  ptr_inc;
  logic [3:0]  ptr_next;
  logic        owner_req;
  logic        others_req;
  logic        hold_at_lim;
  logic        preempt;
  logic        release_bus;

  assign req_v = req_i & ReqMask;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = 4'd0;
    cand       = 5'd0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = 5'(rr_ptr_q) + 5'(k);
      if (cand >= 5'(NUM_REQ)) begin
        cand = cand - 5'(NUM_REQ);
      end
      if (!pick_found && req_v[cand[3:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[3:0];
      end
    end
  end

  always_comb begin
    ptr_inc  = 5'(grant_idx_q) + 5'd1;
    ptr_next = (ptr_inc >= 5'(NUM_REQ)) ? 4'd0 : ptr_inc[3:0];
  end

  assign owner_req   = req_v[grant_idx_q];
  assign others_req  = |(req_v & ~grant_oh_q);
  assign hold_at_lim = int'(hold_cnt_q) >= HoldLim;
  assign preempt     = (MAX_HOLD != 0) && hold_at_lim && !lock_i && others_req;
  assign release_bus = !owner_req || preempt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      rr_ptr_q      <= 4'd0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= 4'd0;
      grant_oh_q    <= 16'd0;
      bus_disable_q <= 1'b1;
      hold_cnt_q    <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle, StTurn: begin
          if (pick_found) begin
            state_q       <= StGrant;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= pick_idx;
            grant_oh_q    <= 16'd1 << pick_idx;
            bus_disable_q <= 1'b0;
            hold_cnt_q    <= 4'd0;
          end else begin
            state_q <= StIdle;
          end
        end
        StGrant: begin
          if (release_bus) begin
            // grant_idx is left stale; it is don't-care while the bus is free.
            state_q       <= StTurn;
            grant_valid_q <= 1'b0;
            grant_oh_q    <= 16'd0;
            bus_disable_q <= 1'b1;
            rr_ptr_q      <= ptr_next;
          end else if (hold_cnt_q != 4'hF) begin
            hold_cnt_q <= hold_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q       <= StIdle;
          grant_valid_q <= 1'b0;
          grant_oh_q    <= 16'd0;
          bus_disable_q <= 1'b1;
        end
      endcase
    end
  end

  assign grant_valid_o = grant_valid_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_oh_o    = grant_oh_q;
  assign bus_disable_o = bus_disable_q;
  assign hold_cnt_o    = hold_cnt_q;

endmodule
